// File: rtl/rx_echo_fifo.sv
// ---------------------------------------------------------------------------
// rx_echo_fifo
//
// Buffer stage in the UART echo path between rx_rs232 and tx_rs232. Every
// byte the receiver completes is queued in a small FIFO. The head byte is
// handed to the transmitter REPEAT times, with GAP_CYCLES idle clocks
// after each transmission completes. Bytes that arrive back to back are
// queued instead of being lost.
//
// Parameters:
//   DATA_WIDTH  byte width
//   DEPTH       FIFO entries (power of 2, >= 2)
//   REPEAT      transmissions per byte (>= 1)
//   GAP_CYCLES  idle clocks after each tx_done before the next tx_en (>= 1)
//
// Ports:
//   clk_i        system clock
//   reset_ni     asynchronous reset, active low
//   flush_i      synchronous clear, active high
//   rx_data_i    received byte
//   rx_done_i    receiver byte-complete flag (rising edge used)
//   tx_busy_i    transmitter busy flag
//   tx_done_i    transmitter frame-complete flag (rising edge used)
//   tx_data_o    byte presented to the transmitter
//   tx_en_o      one-cycle transmit start strobe
//   count_o      FIFO occupancy
//   empty_o      occupancy is zero
//   full_o       occupancy is DEPTH
//   overflow_o   sticky: a received byte was dropped
//   rep_idx_o    repetition index of the byte being echoed
// ---------------------------------------------------------------------------
module rx_echo_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int REPEAT     = 4,
    parameter int GAP_CYCLES = 50_000_000
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          flush_i,
    input  logic [DATA_WIDTH-1:0]         rx_data_i,
    input  logic                          rx_done_i,
    input  logic                          tx_busy_i,
    input  logic                          tx_done_i,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_en_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic                          overflow_o,
    output logic [$clog2(REPEAT+1)-1:0]   rep_idx_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(REPEAT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_POP       = 3'd5;

    // Storage
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // FIFO bookkeeping
    logic [AW-1:0]         wrPtr_q,    wrPtr_d;
    logic [AW-1:0]         rdPtr_q,    rdPtr_d;
    logic [CW-1:0]         count_q,    count_d;
    logic                  empty_q,    empty_d;
    logic                  full_q,     full_d;
    logic                  overflow_q, overflow_d;

    // Echo sequencer
    logic [2:0]            state_q,    state_d;
    logic [RW-1:0]         repIdx_q,   repIdx_d;
    logic [GW-1:0]         gapCnt_q,   gapCnt_d;
    logic [DATA_WIDTH-1:0] txData_q,   txData_d;

    // Edge detection
    logic                  rxDonePrev_q;
    logic                  txDonePrev_q;
    logic                  rxEvt;
    logic                  txEvt;

    logic                  popEn;
    logic                  pushEn;
    logic                  dropEn;

    // The receiver may hold its done flag high for many clocks, so only the
    // rising edge counts as a new byte. Same for the transmitter's done flag.
    assign rxEvt = rx_done_i & ~rxDonePrev_q;
    assign txEvt = tx_done_i & ~txDonePrev_q;

    // A pop frees a slot in the same cycle, so a push arriving while full is
    // still accepted when the sequencer is popping. Flush discards both.
    assign popEn  = (state_q == S_POP) && !flush_i;
    assign pushEn = rxEvt && !flush_i && (!full_q || popEn);
    assign dropEn = rxEvt && !flush_i && full_q && !popEn;

    // Pointer, occupancy and overflow next-state.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush_i) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pushEn) begin
                wrPtr_d = wrPtr_q + AW'(1);
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + AW'(1);
            end
            if (pushEn && !popEn) begin
                count_d = count_q + CW'(1);
            end else if (!pushEn && popEn) begin
                count_d = count_q - CW'(1);
            end
            if (dropEn) begin
                overflow_d = 1'b1;
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == COUNT_FULL);
    end

    // Echo sequencer: load the head byte once, then cycle
    // START -> WAIT_DONE -> GAP for each repetition before popping it.
    always_comb begin
        state_d  = state_q;
        repIdx_d = repIdx_q;
        gapCnt_d = gapCnt_q;
        txData_d = txData_q;

        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                txData_d = mem_q[rdPtr_q];
                repIdx_d = '0;
                state_d  = S_START;
            end

            S_START: begin
                if (!tx_busy_i) begin
                    state_d = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                if (txEvt) begin
                    gapCnt_d = '0;
                    state_d  = S_GAP;
                end
            end

            S_GAP: begin
                if (gapCnt_q == GAP_LAST) begin
                    if (repIdx_q == REP_LAST) begin
                        state_d = S_POP;
                    end else begin
                        repIdx_d = repIdx_q + RW'(1);
                        state_d  = S_START;
                    end
                end else begin
                    gapCnt_d = gapCnt_q + GW'(1);
                end
            end

            S_POP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush abandons the current byte; tx_data keeps its last value and
        // any frame still in the transmitter finishes unobserved.
        if (flush_i) begin
            state_d  = S_IDLE;
            repIdx_d = '0;
        end
    end

    // The start strobe is decoded from state so that it is exactly one cycle
    // wide and drops immediately when reset is asserted.
    assign tx_en_o = (state_q == S_START) && !tx_busy_i && !flush_i;

    // State registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            repIdx_q     <= '0;
            gapCnt_q     <= '0;
            txData_q     <= '0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            rxDonePrev_q <= 1'b0;
            txDonePrev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            repIdx_q     <= repIdx_d;
            gapCnt_q     <= gapCnt_d;
            txData_q     <= txData_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
            rxDonePrev_q <= rx_done_i;
            txDonePrev_q <= tx_done_i;
        end
    end

    // Storage array has no reset; pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= rx_data_i;
        end
    end

    assign tx_data_o  = txData_q;
    assign count_o    = count_q;
    assign empty_o    = empty_q;
    assign full_o     = full_q;
    assign overflow_o = overflow_q;
    assign rep_idx_o  = repIdx_q;

endmodule

// File: tb/tb_rx_echo_fifo.sv
// ---------------------------------------------------------------------------
// tb_rx_echo_fifo
//
// Self-checking bench for rx_echo_fifo with DEPTH=8, REPEAT=4,
// GAP_CYCLES=10. A transmitter model answers each tx_en with tx_busy and a
// tx_done pulse 20 cycles later. Each accepted push queues REPEAT expected
// bytes; the monitor pops one per observed tx_en and compares tx_data.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_rx_echo_fifo;

    localparam int DW     = 8;
    localparam int DEPTH  = 8;
    localparam int REPEAT = 4;
    localparam int GAP    = 10;
    localparam int TXLEN  = 20;

    logic          clk;
    logic          resetN;
    logic          flush;
    logic [DW-1:0] rxData;
    logic          rxDone;
    logic          holdBusy;
    logic          modelBusy;
    logic          modelDone;
    logic          forceDone;
    logic          txBusy;
    logic          txDone;

    logic [DW-1:0] txData;
    logic          txEn;
    logic [3:0]    count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic [2:0]    repIdx;

    assign txBusy = holdBusy | modelBusy;
    assign txDone = modelDone | forceDone;

    int checkCount = 0;
    int passCount  = 0;
    int cycleNo    = 0;
    int peakCount  = 0;

    logic [DW-1:0] expQ[$];
    int            enLog[$];

    rx_echo_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .REPEAT     (REPEAT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (resetN),
        .flush_i    (flush),
        .rx_data_i  (rxData),
        .rx_done_i  (rxDone),
        .tx_busy_i  (txBusy),
        .tx_done_i  (txDone),
        .tx_data_o  (txData),
        .tx_en_o    (txEn),
        .count_o    (count),
        .empty_o    (empty),
        .full_o     (full),
        .overflow_o (overflow),
        .rep_idx_o  (repIdx)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cycleNo);
        end else begin
            passCount++;
        end
    endtask

    // Monitor: counts cycles, tracks peak occupancy and scores every tx_en.
    initial begin
        forever begin
            @(posedge clk);
            cycleNo++;
            @(negedge clk);
            if (int'(count) > peakCount) peakCount = int'(count);
            if (txEn === 1'b1) begin
                enLog.push_back(cycleNo);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_tx_en", 32'd1, 32'd0);
                end else begin
                    checkOutput("tx_data", {24'd0, txData}, {24'd0, expQ.pop_front()});
                end
            end
        end
    end

    // Transmitter model: busy from the cycle after tx_en, tx_done rises
    // TXLEN cycles after tx_en.
    initial begin
        modelBusy = 1'b0;
        modelDone = 1'b0;
        forever begin
            @(negedge clk);
            if (txEn === 1'b1) begin
                for (int i = 1; i < TXLEN; i++) begin
                    @(posedge clk); #1;
                    modelBusy = 1'b1;
                end
                @(posedge clk); #1;
                modelBusy = 1'b0;
                modelDone = 1'b1;
                @(posedge clk); #1;
                modelDone = 1'b0;
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitUntilCycle(input int target);
        while (cycleNo < target) begin
            @(posedge clk); #1;
        end
    endtask

    // One rx_done pulse; an accepted byte queues REPEAT expected echoes.
    task automatic applyStimulus(input logic [DW-1:0] b, input bit accept,
                                 output int evCycle);
        @(posedge clk); #1;
        rxData  = b;
        rxDone  = 1'b1;
        evCycle = cycleNo;
        if (accept) begin
            repeat (REPEAT) expQ.push_back(b);
        end
        @(posedge clk); #1;
        rxDone = 1'b0;
    endtask

    task automatic waitEnCount(input int target, input int budget,
                               input string tag, output bit ok);
        int n = 0;
        while (enLog.size() < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (enLog.size() >= target);
        if (!ok) checkOutput(tag, enLog.size(), target);
    endtask

    task automatic waitDrain(input int budget, input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(tag, expQ.size(), 32'd0);
    endtask

    initial begin
        int ev;
        int base;
        int t;
        int snap;
        bit ok;

        resetN    = 1'b0;
        flush     = 1'b0;
        rxDone    = 1'b0;
        rxData    = '0;
        holdBusy  = 1'b0;
        forceDone = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_tx_en",    {31'd0, txEn},     32'd0);
        checkOutput("rst_tx_data",  {24'd0, txData},   32'd0);
        checkOutput("rst_count",    {28'd0, count},    32'd0);
        checkOutput("rst_empty",    {31'd0, empty},    32'd1);
        checkOutput("rst_full",     {31'd0, full},     32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("rst_rep_idx",  {29'd0, repIdx},   32'd0);
        @(posedge clk); #1;
        resetN = 1'b1;
        waitCycles(3);

        // Single byte echoed four times, 31 cycles apart
        base = enLog.size();
        applyStimulus(8'hA5, 1'b1, ev);
        waitEnCount(base + REPEAT, 400, "t1_tx_en_timeout", ok);
        if (ok) begin
            checkOutput("t1_latency", enLog[base] - ev, 32'd3);
            for (int i = 1; i < REPEAT; i++) begin
                checkOutput("t1_spacing", enLog[base+i] - enLog[base+i-1], 32'd31);
            end
            t = enLog[base+REPEAT-1];
            waitUntilCycle(t + 31);
            @(negedge clk);
            checkOutput("t1_count_before_pop", {28'd0, count}, 32'd1);
            waitUntilCycle(t + 32);
            @(negedge clk);
            checkOutput("t1_count_after_pop", {28'd0, count}, 32'd0);
            checkOutput("t1_empty_after_pop", {31'd0, empty}, 32'd1);
        end
        waitDrain(100, "t1_drain");
        waitCycles(40);
        checkOutput("t1_tx_en_total", enLog.size() - base, REPEAT);

        // Three bytes queued back to back, strict FIFO echo order
        base      = enLog.size();
        peakCount = 0;
        applyStimulus(8'h11, 1'b1, ev);
        applyStimulus(8'h22, 1'b1, ev);
        applyStimulus(8'h33, 1'b1, ev);
        waitDrain(1500, "t2_drain");
        waitCycles(40);
        checkOutput("t2_tx_en_total", enLog.size() - base, 3 * REPEAT);
        checkOutput("t2_peak_count",  peakCount, 32'd3);
        checkOutput("t2_overflow",    {31'd0, overflow}, 32'd0);
        checkOutput("t2_count_end",   {28'd0, count},    32'd0);

        // Overflow with transmitter stalled: ninth byte is dropped
        base     = enLog.size();
        holdBusy = 1'b1;
        for (int b = 0; b <= DEPTH; b++) begin
            applyStimulus(8'(b), (b < DEPTH), ev);
        end
        waitCycles(2);
        @(negedge clk);
        checkOutput("t3_count_full", {28'd0, count},    32'd8);
        checkOutput("t3_full",       {31'd0, full},     32'd1);
        checkOutput("t3_empty",      {31'd0, empty},    32'd0);
        checkOutput("t3_overflow",   {31'd0, overflow}, 32'd1);
        @(posedge clk); #1;
        holdBusy = 1'b0;
        waitDrain(2000, "t3_drain");
        waitCycles(40);
        checkOutput("t3_tx_en_total", enLog.size() - base, DEPTH * REPEAT);
        checkOutput("t3_count_end",   {28'd0, count}, 32'd0);

        // rx_done held high: a single push
        base     = enLog.size();
        holdBusy = 1'b1;
        @(posedge clk); #1;
        rxData = 8'h5A;
        rxDone = 1'b1;
        repeat (REPEAT) expQ.push_back(8'h5A);
        waitCycles(100);
        rxDone = 1'b0;
        waitCycles(2);
        @(negedge clk);
        checkOutput("t4_count_held",    {28'd0, count},    32'd1);
        checkOutput("t4_overflow_kept", {31'd0, overflow}, 32'd1);
        @(posedge clk); #1;
        holdBusy = 1'b0;
        waitDrain(400, "t4_drain");
        waitCycles(40);
        checkOutput("t4_tx_en_total", enLog.size() - base, REPEAT);

        // Asynchronous reset while waiting for tx_done
        base = enLog.size();
        applyStimulus(8'h66, 1'b1, ev);
        applyStimulus(8'h77, 1'b1, ev);
        waitEnCount(base + 1, 50, "t5_tx_en_timeout", ok);
        waitCycles(5);
        @(negedge clk); #2;
        resetN = 1'b0;
        #1;
        checkOutput("t5_async_tx_en",    {31'd0, txEn},     32'd0);
        checkOutput("t5_async_count",    {28'd0, count},    32'd0);
        checkOutput("t5_async_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("t5_async_empty",    {31'd0, empty},    32'd1);
        expQ.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetN = 1'b1;
        waitCycles(40);
        base = enLog.size();
        applyStimulus(8'h3C, 1'b1, ev);
        waitEnCount(base + 1, 20, "t5_post_reset_timeout", ok);
        if (ok) begin
            checkOutput("t5_post_reset_latency", enLog[base] - ev, 32'd3);
        end
        waitDrain(300, "t5_drain");
        waitCycles(40);

        // Flush during the gap of the second repetition
        base = enLog.size();
        applyStimulus(8'h44, 1'b1, ev);
        applyStimulus(8'h55, 1'b1, ev);
        waitEnCount(base + 2, 100, "t6_tx_en_timeout", ok);
        if (ok) begin
            t = enLog[base+1];
            waitUntilCycle(t + 24);
            @(negedge clk);
            checkOutput("t6_count_before_flush", {28'd0, count},  32'd2);
            checkOutput("t6_rep_before_flush",   {29'd0, repIdx}, 32'd1);
            waitUntilCycle(t + 25);
            flush = 1'b1;
            expQ.delete();
            @(posedge clk); #1;
            flush = 1'b0;
            @(negedge clk);
            checkOutput("t6_flush_count", {28'd0, count},  32'd0);
            checkOutput("t6_flush_empty", {31'd0, empty},  32'd1);
            checkOutput("t6_flush_rep",   {29'd0, repIdx}, 32'd0);
            checkOutput("t6_flush_tx_en", {31'd0, txEn},   32'd0);
            snap = enLog.size();
            waitCycles(50);
            checkOutput("t6_no_tx_en_after_flush", enLog.size(), snap);
            forceDone = 1'b1;
            @(posedge clk); #1;
            forceDone = 1'b0;
            waitCycles(30);
            checkOutput("t6_late_tx_done_ignored", enLog.size(), snap);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rx_echo_fifo.md
Name: rx_echo_fifo

Overview:
- Buffer stage between rx_rs232 and tx_rs232 in the UART echo path.
- Captures each byte the receiver completes into a small FIFO.
- Drives tx_rs232 one byte at a time. Each byte is echoed REPEAT times, separated by a programmable inter-frame gap.
- Replaces the ad-hoc send counter and one-second timer gating in the top level, so back-to-back received bytes are no longer lost.

Parameters:
- DATA_WIDTH, 8, byte width.
- DEPTH, 8, FIFO entries. Must be a power of 2, at least 2.
- REPEAT, 4, transmissions per byte. Must be at least 1.
- GAP_CYCLES, 50_000_000, idle clocks after each tx_done before the next tx_en. 1 s at 50 MHz. Must be at least 1.

Ports:
- clk, in, 1: system clock (iCLK_50).
- reset, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous clear, active-high.
- rx_data, in, DATA_WIDTH: received byte (rx_rs232 received_data).
- rx_done, in, 1: rx_rs232 all_bits_received. Level or pulse; only its rising edge is used.
- tx_busy, in, 1: tx_rs232 transmitting_flag.
- tx_done, in, 1: tx_rs232 all_bits_transmitted. Only its rising edge is used.
- tx_data, out, DATA_WIDTH: byte presented to tx_rs232 transmit_data.
- tx_en, out, 1: one-cycle start strobe to tx_rs232.
- count, out, $clog2(DEPTH)+1: FIFO occupancy.
- empty, out, 1: count==0.
- full, out, 1: count==DEPTH.
- overflow, out, 1: sticky flag, set when a byte is dropped.
- rep_idx, out, $clog2(REPEAT+1): current repetition index of the head byte.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - tx_en=0, tx_data=0, count=0, empty=1, full=0, overflow=0, rep_idx=0.
  - Read and write pointers = 0.
  - Edge-detect registers = 0.
- Edge detection: rx_done and tx_done each have a previous-value register. Event = current & ~previous. A held-high level therefore counts once.
- Push, on an rx_done event in cycle N:
  - If the FIFO is not full after accounting for a same-cycle pop, write rx_data at wr_ptr and advance wr_ptr (mod DEPTH).
  - count, empty and full are registered and update at N+1.
  - Full with no same-cycle pop: the byte is dropped, overflow is set to 1, and FIFO contents are unchanged.
- FSM states: IDLE, LOAD, START, WAIT_DONE, GAP, POP.
  - IDLE: if !empty, go to LOAD.
  - LOAD: tx_data <= mem[rd_ptr]; rep_idx <= 0; go to START. tx_data then stays stable through all repeats of that byte.
  - START: if !tx_busy, assert tx_en for exactly this cycle and go to WAIT_DONE. Otherwise stay in START with tx_en=0.
  - WAIT_DONE: on a tx_done event, clear the gap counter and go to GAP. No timeout.
  - GAP: increment the gap counter. When it reaches GAP_CYCLES-1:
    - if rep_idx==REPEAT-1, go to POP;
    - else rep_idx <= rep_idx+1 and go to START.
  - POP: rd_ptr advances (mod DEPTH), count decrements, go to IDLE. tx_data holds its last value.
- Latency:
  - Byte pushed into an empty FIFO in IDLE: the rx_done event is in cycle N and tx_en goes high at N+3, provided tx_busy=0.
  - Gap: tx_done event at cycle M; the next tx_en is at M+GAP_CYCLES+1.
- Simultaneous push and pop: both take effect and count is unchanged. At full, the push is accepted.
- Pointer wrap: natural wrap at DEPTH. Ordering is strict FIFO.
- flush=1:
  - Next cycle: state IDLE, pointers 0, count 0, overflow 0, rep_idx 0, tx_en 0.
  - A push in the same cycle is discarded.
  - A transmission already in tx_rs232 is not aborted; its tx_done is ignored.
- reset asserted mid-transmission: all state is cleared immediately and tx_en is forced low asynchronously.
- Gap counter width is $clog2(GAP_CYCLES+1).

Test Plan:
- Reset, then one byte 0xA5 on rx_done, REPEAT=4, GAP_CYCLES=10, tx_done modelled 20 cycles after each tx_en:
  - tx_en pulses exactly 4 times, each tx_data=0xA5;
  - consecutive tx_en are 31 cycles apart;
  - count returns to 0 after POP.
- Push 0x11, 0x22, 0x33 back-to-back (rx_done events 2 cycles apart) during the first repeat of 0x11:
  - echo order is 4×0x11, 4×0x22, 4×0x33;
  - count peaks at 3;
  - overflow stays 0.
- DEPTH=8, tx_busy held at 1, push 9 bytes 0x00..0x08:
  - count=8, full=1, overflow=1;
  - after tx_busy is released, output is 0x00..0x07 and 0x08 is never sent.
- rx_done held high for 100 cycles with rx_data=0x5A:
  - exactly one push, count=1.
- flush asserted in GAP with 2 bytes queued:
  - next cycle count=0, empty=1, state IDLE;
  - no further tx_en;
  - a late tx_done pulse causes no tx_en.
- reset driven low asynchronously mid-WAIT_DONE:
  - tx_en=0, count=0, overflow=0 without a clock edge;
  - after release, a new push of 0x3C produces tx_en 3 cycles after its rx_done event.
